// File: rtl/uart_tx.sv
// Purpose : UART transmitter with a byte FIFO in front of a START/DATA/PARITY/STOP framer.
// Latency : a byte pushed into an empty idle block drives the start bit two cycles later;
//           queued frames follow each other with no idle gap.
// Backpr. : no ready signal; a push while full is dropped and latches the sticky overflow flag.
//
// Ports:
//   clk, reset (async, active-low)
//   we/din      : byte push request and data
//   divisor     : bit period = divisor+1 clk cycles
//   data_bits_count, parity_type, double_stop_bits : frame format, sampled at frame start
//   irq_en      : enables irq = irq_en & empty & !busy
//   tx          : serial line (idle high); full/empty/busy/overflow status
//
// Build option: define UART_TX_PARITY_EN to build the parity bit and the PARITY state.
// Without it parity_type is ignored and frames never carry a parity bit.

module uart_tx #(
  parameter int TX_QUEUE_SIZE = 16,
  parameter int DIVISOR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [7:0]               din,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  input  logic [1:0]               data_bits_count,
  input  logic [1:0]               parity_type,
  input  logic                     double_stop_bits,
  input  logic                     irq_en,
  output logic                     tx,
  output logic                     full,
  output logic                     empty,
  output logic                     busy,
  output logic                     overflow,
  output logic                     irq
);

  localparam int AW = $clog2(TX_QUEUE_SIZE);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [TX_QUEUE_SIZE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          push;
  logic          pop;

  // ---------------------------------------------------------------- framer
  state_t                   state_q, state_d;
  logic [7:0]               shift_q, shift_d;
  logic [1:0]               nbits_q, nbits_d;
  logic                     dstop_q, dstop_d;
  logic [DIVISOR_WIDTH-1:0] div_q, div_d;
  logic [DIVISOR_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic                     bit_done;
  logic                     last_bit;
  logic                     start_frame;
  logic                     frame_end;
  logic                     par_en;

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic [7:0] load_byte;
  logic [7:0] data_mask;
  assign par_en = par_en_q;
`else
  logic unused_parity_type;
  assign unused_parity_type = ^parity_type;
  assign par_en = 1'b0;
`endif

  // FIFO bookkeeping; pop is only ever raised by the framer when empty_q is low.
  always_comb begin
    push       = we & ~full_q;
    overflow_d = overflow_q | (we & full_q);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(TX_QUEUE_SIZE));
  end

  // Storage needs no reset: validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Framer next-state logic.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    nbits_d     = nbits_q;
    dstop_d     = dstop_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    bit_done    = (cnt_q == div_q);
    last_bit    = (bit_idx_q == ({1'b0, nbits_q} + 3'd4));

    // One free-running period counter shared by every bit-timed state.
    if (state_q != IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + DIVISOR_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        start_frame = ~empty_q;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (last_bit) state_d = par_en ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP1;
      end
      STOP1: begin
        if (bit_done) begin
          if (dstop_q) state_d = STOP2;
          else         frame_end = 1'b1;
        end
      end
      STOP2: begin
        if (bit_done) frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Finishing the last stop bit behaves like IDLE in the same cycle, so a
    // queued byte starts on the very next cycle with no idle gap.
    if (frame_end) begin
      state_d     = IDLE;
      start_frame = ~empty_q;
    end

    if (start_frame) begin
      pop       = 1'b1;
      shift_d   = mem_q[rd_ptr_q];
      nbits_d   = data_bits_count;
      dstop_d   = double_stop_bits;
      div_d     = divisor;
      cnt_d     = '0;
      bit_idx_d = '0;
      state_d   = START;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is computed once at load time over exactly the bits that will be sent.
  always_comb begin
    load_byte = mem_q[rd_ptr_q];
    data_mask = 8'hFF >> (2'd3 - data_bits_count);
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (start_frame) begin
      par_en_d  = (parity_type == 2'b01) | (parity_type == 2'b10);
      par_bit_d = (^(load_byte & data_mask)) ^ (parity_type == 2'b10);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      nbits_q    <= '0;
      dstop_q    <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      dstop_q    <= dstop_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  // tx is decoded straight from the state so reset forces the line high
  // asynchronously.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = par_bit_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign irq      = irq_en & empty_q & ~busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-based line model predicts tx and all status
// outputs every cycle; directed frames add hand-computed literal checks.

module tb_uart_tx;

  localparam int QS = 4;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          we;
  logic [7:0]    din;
  logic [DW-1:0] divisor;
  logic [1:0]    data_bits_count;
  logic [1:0]    parity_type;
  logic          double_stop_bits;
  logic          irq_en;
  logic          tx, full, empty, busy, overflow, irq;

  uart_tx #(.TX_QUEUE_SIZE(QS), .DIVISOR_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .we               (we),
    .din              (din),
    .divisor          (divisor),
    .data_bits_count  (data_bits_count),
    .parity_type      (parity_type),
    .double_stop_bits (double_stop_bits),
    .irq_en           (irq_en),
    .tx               (tx),
    .full             (full),
    .empty            (empty),
    .busy             (busy),
    .overflow         (overflow),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ line model
  // m_fifo holds accepted bytes; m_line holds the tx level for each upcoming cycle
  // of the frame in flight (head = current cycle).
  logic [7:0] m_fifo[$];
  bit         m_line[$];
  bit         m_ovf = 1'b0;
  int         m_pre;
  bit         m_dummy;

  task automatic expand(input logic [7:0] b);
    int per;
    int n;
    bit p;
    bit pb;
    per = int'(divisor) + 1;
    n   = 5 + int'(data_bits_count);
    p   = 1'b0;
    pb  = 1'b0;
    for (int i = 0; i < per; i++) m_line.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      p ^= b[k];
      for (int i = 0; i < per; i++) m_line.push_back(b[k]);
    end
`ifdef UART_TX_PARITY_EN
    if (parity_type == 2'b01 || parity_type == 2'b10) begin
      pb = (parity_type == 2'b10) ? ~p : p;
      for (int i = 0; i < per; i++) m_line.push_back(pb);
    end
`endif
    for (int i = 0; i < per; i++) m_line.push_back(1'b1);
    if (double_stop_bits) for (int i = 0; i < per; i++) m_line.push_back(1'b1);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 1'b0;
    end else begin
      m_pre = m_fifo.size();
      if (m_line.size() > 0) m_dummy = m_line.pop_front();
      if (m_line.size() == 0 && m_pre > 0) expand(m_fifo.pop_front());
      if (we) begin
        if (m_pre < QS) m_fifo.push_back(din);
        else            m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("tx",       tx,       (m_line.size() > 0) ? m_line[0] : 1'b1);
    check("busy",     busy,     m_line.size() > 0);
    check("empty",    empty,    m_fifo.size() == 0);
    check("full",     full,     m_fifo.size() == QS);
    check("overflow", overflow, m_ovf);
    check("irq",      irq,      irq_en & (m_fifo.size() == 0) & (m_line.size() == 0));
  end

  // ------------------------------------------------------------ helpers
  bit cap [0:511];

  task automatic cfg(input logic [DW-1:0] dv, input logic [1:0] nb,
                     input logic [1:0] pt, input logic ds);
    @(posedge clk); #1;
    divisor = dv; data_bits_count = nb; parity_type = pt; double_stop_bits = ds;
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    we = 1'b1; din = b;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Counts cycles from the push cycle until busy is seen (push cycle = 0).
  task automatic wait_busy(output int lat);
    lat = 1;
    @(negedge clk);
    while (!busy && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic capture(output int len);
    len = 0;
    while (busy && len < 512) begin
      cap[len] = tx;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic count_busy(output int b);
    b = 0;
    @(negedge clk);
    while (busy && b < 2000) begin
      b++;
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] sample_bits(input int per, input int nb);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < nb; j++) v[j] = cap[j * per + per / 2];
    return v;
  endfunction

  // ------------------------------------------------------------ stimulus
  int lat;
  int len;
  int nbusy;

  initial begin
    reset = 1'b0; we = 1'b0; din = 8'h00;
    divisor = 16'd3; data_bits_count = 2'd3; parity_type = 2'b00;
    double_stop_bits = 1'b0; irq_en = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_irq", irq, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;

    // 8N1, divisor 3, 0x55
    cfg(16'd3, 2'd3, 2'b00, 1'b0);
    push(8'h55);
    wait_busy(lat);
    check("t1_latency", lat, 2);
    capture(len);
    check("t1_len", len, 40);
    check("t1_bits", sample_bits(4, 10), 64'h2AA);

    // 7 bits, even parity, divisor 0, 0x03
    cfg(16'd0, 2'd2, 2'b01, 1'b0);
    push(8'h03);
    wait_busy(lat);
    check("t2_latency", lat, 2);
    capture(len);
`ifdef UART_TX_PARITY_EN
    check("t2_len", len, 10);
    check("t2_bits", sample_bits(1, 10), 64'h206);
`else
    check("t2_len", len, 9);
    check("t2_bits", sample_bits(1, 9), 64'h106);
`endif

    // 5 bits, odd parity, two stop bits, divisor 1, 0x1F
    cfg(16'd1, 2'd0, 2'b10, 1'b1);
    push(8'h1F);
    wait_busy(lat);
    capture(len);
`ifdef UART_TX_PARITY_EN
    check("t3_len", len, 18);
    check("t3_bits", sample_bits(2, 9), 64'h1BE);
`else
    check("t3_len", len, 16);
    check("t3_bits", sample_bits(2, 8), 64'hFE);
`endif

    // Six consecutive pushes into a 4-deep queue, divisor 7, 8N1
    cfg(16'd7, 2'd3, 2'b00, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      we = 1'b1; din = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    we = 1'b0;
    check("t4_full", full, 1'b1);
    check("t4_ovf", overflow, 1'b1);
    check("t4_empty", empty, 1'b0);
    count_busy(nbusy);
    check("t4_busy_run", nbusy, 396);
    check("t4_drained", empty, 1'b1);
    check("t4_ovf_sticky", overflow, 1'b1);

    // Configuration change mid-frame: divisor 1 -> 3, parity even -> odd
    cfg(16'd1, 2'd3, 2'b01, 1'b0);
    @(posedge clk); #1;
    we = 1'b1; din = 8'h0F;
    @(posedge clk); #1;
    din = 8'hF0;
    @(posedge clk); #1;
    we = 1'b0;
    divisor = 16'd3; parity_type = 2'b10;
    count_busy(nbusy);
`ifdef UART_TX_PARITY_EN
    check("t5_busy_run", nbusy, 66);
`else
    check("t5_busy_run", nbusy, 60);
`endif

    // Reset in the middle of DATA of 0xA5
    cfg(16'd3, 2'd3, 2'b00, 1'b0);
    push(8'hA5);
    wait_busy(lat);
    repeat (9) @(negedge clk);
    check("t6_pre_tx", tx, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("t6_rst_tx", tx, 1'b1);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_empty", empty, 1'b1);
    check("t6_rst_ovf", overflow, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_idle_tx", tx, 1'b1);
    check("t6_idle_busy", busy, 1'b0);
    check("t6_irq_on", irq, 1'b1);
    @(posedge clk); #1;
    irq_en = 1'b0;
    @(negedge clk);
    check("t6_irq_off", irq, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter TX_QUEUE_SIZE, default 16, SHALL set the transmit FIFO depth in bytes (power of two, >=2).
REQ-002 Parameter DIVISOR_WIDTH, default 16, SHALL set the width of the baud divisor input.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 we  input  1  SHALL request a push of din into the FIFO.
REQ-006 din  input  8  SHALL carry the byte to push.
REQ-007 divisor  input  DIVISOR_WIDTH  SHALL set the bit period to divisor+1 clk cycles.
REQ-008 data_bits_count  input  2  SHALL select 5+value data bits per frame.
REQ-009 parity_type  input  2  SHALL select parity: 00 none, 01 even, 10 odd, 11 none.
REQ-010 double_stop_bits  input  1  SHALL select two stop bits when 1.
REQ-011 irq_en  input  1  SHALL enable the idle interrupt.
REQ-012 tx  output  1  SHALL be the serial line, idle high.
REQ-013 full, empty  output  1 each  SHALL reflect FIFO state.
REQ-014 busy  output  1  SHALL be 1 while a frame is on the line.
REQ-015 overflow  output  1  SHALL be a sticky flag set by a push attempt while full.
REQ-016 irq  output  1  SHALL equal irq_en & empty & !busy.

Function
REQ-017 A push SHALL occur when we=1 and full=0; we=1 with full=1 SHALL drop din, leave FIFO unchanged and set overflow.
REQ-018 overflow SHALL clear only on reset.
REQ-019 full and empty SHALL be registered; a push in cycle N SHALL deassert empty in cycle N+1.
REQ-020 FIFO pointers SHALL wrap modulo TX_QUEUE_SIZE; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-022 IDLE: tx=1; if empty=0, pop one byte into the shift register, latch data_bits_count, parity_type, double_stop_bits and divisor, go to START.
REQ-023 Configuration inputs changing mid-frame SHALL not affect the frame in progress.
REQ-024 A byte pushed in cycle N into an empty idle block SHALL drive tx low from cycle N+2.
REQ-025 START, each DATA bit, PARITY, STOP1 and STOP2 SHALL each last exactly latched divisor+1 cycles; divisor=0 gives one cycle per bit.
REQ-026 START SHALL drive tx=0; DATA SHALL send bits LSB first, 5+data_bits_count bits, then PARITY if enabled, else STOP1.
REQ-027 PARITY SHALL send the XOR of the sent data bits (even) or its inverse (odd).
REQ-028 STOP1/STOP2 SHALL drive tx=1; after STOP1 go to STOP2 if double_stop_bits latched, else IDLE; STOP2 goes to IDLE.
REQ-029 After the last stop bit, IDLE SHALL pop the next byte immediately when the FIFO is non-empty, giving back-to-back frames with no extra idle cycles.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 The bit-period counter SHALL restart at 0 on entry to START and after each completed bit.

Reset
REQ-032 While reset=0: FSM=IDLE, tx=1, busy=0, FIFO empty (empty=1, full=0), overflow=0, counters 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, drive tx=1 asynchronously and discard the FIFO contents.

Configuration
REQ-034 Macro UART_TX_PARITY_EN defined: parity logic and PARITY state SHALL be built per REQ-009/REQ-027.
REQ-035 Macro UART_TX_PARITY_EN undefined: parity_type SHALL be ignored, PARITY SHALL never be entered, and frames SHALL have no parity bit.

Verification
REQ-036 divisor=3, 8N1, push 0x55 -> tx: 4 cycles low, then 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles high; busy for 40 cycles.
REQ-037 divisor=0, 7 bits, even parity, push 0x03 -> start, 1,1,0,0,0,0,0, parity 0, stop; 10 cycles total.
REQ-038 divisor=1, 5 bits, odd parity, two stop bits, push 0x1F -> parity bit 0, two stop bits of 2 cycles each, frame 18 cycles.
REQ-039 TX_QUEUE_SIZE=4, divisor=7, push 6 bytes in consecutive cycles -> bytes 1-5 accepted (first pops immediately), full=1 after 5th, 6th dropped, overflow=1; 5 frames back-to-back.
REQ-040 Reset pulled low mid-DATA of 0xA5 -> tx=1 at once, empty=1, busy=0; after release with no push, tx stays high and irq=irq_en.
REQ-041 Change parity_type and divisor during a frame -> current frame unchanged; next frame uses the new values.
